pci_master_initiator: RTL and testbench

- Single PCI bus initiator that sits upstream of the bus arbiter and produces one REQ line of the arbiter's 3-bit REQ vector.
- It consumes the matching GNT line and runs a burst transaction: one address phase plus 1..7 data phases.
- Bus-side handshakes are active-low, matching the arbiter.
- A local-side start/done interface lets the device core issue reads and writes.

---
 rtl/pci_master_initiator.sv | 219 +++++++++++++++++++++
 tb/tb_pci_master_initiator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_master_initiator.sv
// PCI bus initiator: REQ/GNT arbitration, one address phase, then a 1..7 word burst with DEVSEL master-abort timeout.
// Optional even parity output PAR when PCI_MASTER_PARITY_EN is defined.
module pci_master_initiator #(
   parameter int DEVSEL_TIMEOUT = 5,
   parameter int MAX_WORDS      = 7
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        start,
   input  logic [3:0]  cmd,
   input  logic [31:0] addr,
   input  logic [2:0]  num_words,
   input  logic [31:0] wr_data,
   output logic        wr_data_ack,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic        done,
   output logic        abort,
   output logic        REQ,
   input  logic        GNT,
   output logic        FRAME,
   output logic        IRDY,
   input  logic        TRDY,
   input  logic        DEVSEL,
   output logic [31:0] AD_out,
   input  logic [31:0] AD_in,
   output logic        AD_oe,
   output logic [3:0]  CBE
`ifdef PCI_MASTER_PARITY_EN
   ,
   output logic        PAR
`endif
);

   localparam int         TW    = $clog2(DEVSEL_TIMEOUT + 1);
   localparam logic [2:0] MAX_W = 3'(MAX_WORDS);

   typedef enum logic [2:0] {S_IDLE, S_REQUEST, S_ADDR, S_DATA, S_ABORT, S_TURN} state_t;

   state_t          state, state_nxt;
   logic [3:0]      cmd_q, cmd_nxt;
   logic [31:0]     addr_q, addr_nxt;
   logic [2:0]      remaining, rem_nxt;
   logic [TW-1:0]   tcnt, tcnt_nxt;
   logic            devsel_seen, seen_nxt;
   logic            req_nxt, frame_nxt, irdy_nxt, ad_oe_nxt, busy_nxt;
   logic            done_nxt, abort_nxt, rd_valid_nxt, wr_ack_nxt;
   logic [31:0]     ad_out_nxt, rd_data_nxt;
   logic [3:0]      cbe_nxt;
   logic            is_write, transfer, timeout_hit;

   assign is_write    = cmd_q[0];
   assign transfer    = (state == S_DATA) && !IRDY && !TRDY;
   // a transfer in the same cycle beats the timeout
   assign timeout_hit = (state == S_DATA) && !transfer && DEVSEL && !devsel_seen &&
                        (tcnt == TW'(DEVSEL_TIMEOUT - 1));

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state       <= S_IDLE;
         cmd_q       <= '0;
         addr_q      <= '0;
         remaining   <= '0;
         tcnt        <= '0;
         devsel_seen <= 1'b0;
         REQ         <= 1'b1;
         FRAME       <= 1'b1;
         IRDY        <= 1'b1;
         AD_oe       <= 1'b0;
         AD_out      <= '0;
         CBE         <= 4'hF;
         rd_data     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         abort       <= 1'b0;
         rd_valid    <= 1'b0;
         wr_data_ack <= 1'b0;
      end else begin
         state       <= state_nxt;
         cmd_q       <= cmd_nxt;
         addr_q      <= addr_nxt;
         remaining   <= rem_nxt;
         tcnt        <= tcnt_nxt;
         devsel_seen <= seen_nxt;
         REQ         <= req_nxt;
         FRAME       <= frame_nxt;
         IRDY        <= irdy_nxt;
         AD_oe       <= ad_oe_nxt;
         AD_out      <= ad_out_nxt;
         CBE         <= cbe_nxt;
         rd_data     <= rd_data_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         abort       <= abort_nxt;
         rd_valid    <= rd_valid_nxt;
         wr_data_ack <= wr_ack_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_REQUEST;
         S_REQUEST: if (!GNT) state_nxt = S_ADDR;
         S_ADDR:    state_nxt = S_DATA;
         S_DATA: begin
            if (transfer && remaining == 3'd1) state_nxt = S_TURN;
            else if (timeout_hit)              state_nxt = S_ABORT;
         end
         S_ABORT:   state_nxt = S_TURN;
         S_TURN:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Outputs are computed for the state being entered and registered, so wait states simply hold.
   always_comb begin
      cmd_nxt      = cmd_q;
      addr_nxt     = addr_q;
      rem_nxt      = remaining;
      tcnt_nxt     = tcnt;
      seen_nxt     = devsel_seen;
      req_nxt      = REQ;
      frame_nxt    = FRAME;
      irdy_nxt     = IRDY;
      ad_oe_nxt    = AD_oe;
      ad_out_nxt   = AD_out;
      cbe_nxt      = CBE;
      rd_data_nxt  = rd_data;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      abort_nxt    = 1'b0;
      rd_valid_nxt = 1'b0;
      wr_ack_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               cmd_nxt  = cmd;
               addr_nxt = addr;
               if (num_words == 3'd0)      rem_nxt = 3'd1;
               else if (num_words > MAX_W) rem_nxt = MAX_W;
               else                        rem_nxt = num_words;
               busy_nxt = 1'b1;
               req_nxt  = 1'b0;
            end
         end
         S_REQUEST: begin
            if (!GNT) begin
               frame_nxt  = 1'b0;
               irdy_nxt   = 1'b1;
               req_nxt    = 1'b1;
               ad_oe_nxt  = 1'b1;
               ad_out_nxt = addr_q;
               cbe_nxt    = cmd_q;
               tcnt_nxt   = '0;
               seen_nxt   = 1'b0;
            end
         end
         S_ADDR: begin
            irdy_nxt   = 1'b0;
            cbe_nxt    = 4'b0000;
            frame_nxt  = (remaining > 3'd1) ? 1'b0 : 1'b1;
            ad_oe_nxt  = is_write;
            ad_out_nxt = is_write ? wr_data : '0;
         end
         S_DATA: begin
            if (transfer) begin
               rem_nxt      = remaining - 3'd1;
               seen_nxt     = 1'b1;
               wr_ack_nxt   = is_write;
               rd_valid_nxt = !is_write;
               if (!is_write) rd_data_nxt = AD_in;
               if (remaining == 3'd1) begin
                  frame_nxt = 1'b1;
                  irdy_nxt  = 1'b1;
                  ad_oe_nxt = 1'b0;
                  cbe_nxt   = 4'hF;
                  done_nxt  = 1'b1;
               end else begin
                  frame_nxt = (remaining > 3'd2) ? 1'b0 : 1'b1;
                  if (is_write) ad_out_nxt = wr_data;
               end
            end else if (!DEVSEL) begin
               seen_nxt = 1'b1;
            end else if (!devsel_seen) begin
               tcnt_nxt = tcnt + TW'(1);
               if (timeout_hit) begin
                  frame_nxt = 1'b1;
                  irdy_nxt  = 1'b1;
                  ad_oe_nxt = 1'b0;
                  abort_nxt = 1'b1;
               end
            end
         end
         S_ABORT: begin
            frame_nxt = 1'b1;
            irdy_nxt  = 1'b1;
            ad_oe_nxt = 1'b0;
            cbe_nxt   = 4'hF;
         end
         S_TURN: busy_nxt = 1'b0;
         default: ;
      endcase
   end

`ifdef PCI_MASTER_PARITY_EN
   // parity covers the phase that just completed; read transactions leave PAR at 0
   always_ff @(posedge clk or posedge RST) begin
      if (RST)
         PAR <= 1'b0;
      else if (is_write && (state == S_ADDR || transfer))
         PAR <= ^{AD_out, CBE};
      else if (!is_write)
         PAR <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_pci_master_initiator.sv
// Directed bench for pci_master_initiator: stimulus pushes expected local-side events, a monitor pops and compares.
module tb_pci_master_initiator;

   logic        clk = 1'b0;
   logic        RST;
   logic        start;
   logic [3:0]  cmd;
   logic [31:0] addr;
   logic [2:0]  num_words;
   logic [31:0] wr_data;
   logic        wr_data_ack;
   logic [31:0] rd_data;
   logic        rd_valid, busy, done, abort;
   logic        REQ, GNT, FRAME, IRDY, TRDY, DEVSEL, AD_oe;
   logic [31:0] AD_out, AD_in;
   logic [3:0]  CBE;
`ifdef PCI_MASTER_PARITY_EN
   logic        PAR;
`endif

   pci_master_initiator dut (
      .clk(clk), .RST(RST), .start(start), .cmd(cmd), .addr(addr), .num_words(num_words),
      .wr_data(wr_data), .wr_data_ack(wr_data_ack), .rd_data(rd_data), .rd_valid(rd_valid),
      .busy(busy), .done(done), .abort(abort), .REQ(REQ), .GNT(GNT), .FRAME(FRAME),
      .IRDY(IRDY), .TRDY(TRDY), .DEVSEL(DEVSEL), .AD_out(AD_out), .AD_in(AD_in),
      .AD_oe(AD_oe), .CBE(CBE)
`ifdef PCI_MASTER_PARITY_EN
      , .PAR(PAR)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [1:0] EV_ACK = 2'd0, EV_RD = 2'd1, EV_DONE = 2'd2, EV_ABORT = 2'd3;
   typedef struct {
      logic [1:0]  kind;
      logic [31:0] data;
   } ev_t;
   ev_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [31:0] d);
      ev_t e;
      e.kind = k;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [1:0] k, input logic [31:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_unexpected: got event kind %0d data %h expected none", k, d);
      end else begin
         e = exp_q.pop_front();
         chk("sb_kind", 32'(k), 32'(e.kind));
         if (e.kind == EV_RD) chk("sb_rd_data", d, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (!RST) begin
         if (wr_data_ack) sb_pop(EV_ACK, 32'h0);
         if (rd_valid)    sb_pop(EV_RD, rd_data);
         if (done)        sb_pop(EV_DONE, 32'h0);
         if (abort)       sb_pop(EV_ABORT, 32'h0);
      end
   end

   // Called at a negedge; returns at the negedge inside the address phase with GNT released.
   task automatic begin_txn(input logic [3:0] c, input logic [31:0] a, input logic [2:0] nw,
                            input logic [31:0] wd, input int gnt_dly, input bit poke);
      cmd = c; addr = a; num_words = nw; wr_data = wd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("req_busy", 32'(busy), 32'd1);
      chk("req_low", 32'(REQ), 32'd0);
      if (poke) begin
         start = 1'b1; cmd = 4'b0110; addr = 32'h0000_0BAD;
         @(negedge clk);
         start = 1'b0;
      end
      repeat (gnt_dly) @(negedge clk);
      GNT = 1'b0;
      @(negedge clk);
      chk("addr_frame", 32'(FRAME), 32'd0);
      chk("addr_irdy", 32'(IRDY), 32'd1);
      chk("addr_oe", 32'(AD_oe), 32'd1);
      chk("addr_ad", AD_out, a);
      chk("addr_cbe", 32'(CBE), 32'(c));
      chk("addr_req", 32'(REQ), 32'd1);
      GNT = 1'b1;
   endtask

   task automatic run_single(input logic [3:0] c, input logic [31:0] a, input logic [2:0] nw,
                             input logic [31:0] d, input int gnt_dly, input int trdy_dly,
                             input bit poke);
      if (c[0]) push(EV_ACK, 32'h0);
      else      push(EV_RD, d);
      push(EV_DONE, 32'h0);
      begin_txn(c, a, nw, d, gnt_dly, poke);
      @(negedge clk);
      chk("data_irdy", 32'(IRDY), 32'd0);
      chk("data_frame_last", 32'(FRAME), 32'd1);
      chk("data_cbe", 32'(CBE), 32'd0);
      chk("data_oe", 32'(AD_oe), 32'(c[0]));
      if (c[0]) chk("data_ad", AD_out, d);
      repeat (trdy_dly) @(negedge clk);
      chk("wait_irdy", 32'(IRDY), 32'd0);
      DEVSEL = 1'b0; TRDY = 1'b0; AD_in = d;
      @(negedge clk);
      DEVSEL = 1'b1; TRDY = 1'b1;
      chk("turn_frame", 32'(FRAME), 32'd1);
      chk("turn_irdy", 32'(IRDY), 32'd1);
      chk("turn_oe", 32'(AD_oe), 32'd0);
      chk("turn_cbe", 32'(CBE), 32'hF);
      if (poke) begin
         start = 1'b1; cmd = 4'b0110; addr = 32'h0000_0BAD;
      end
      @(negedge clk);
      start = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_req", 32'(REQ), 32'd1);
      @(negedge clk);
      chk("idle_req_hold", 32'(REQ), 32'd1);
      chk("idle_busy_hold", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; start = 1'b0; cmd = 4'h0; addr = '0; num_words = '0; wr_data = '0;
      GNT = 1'b1; TRDY = 1'b1; DEVSEL = 1'b1; AD_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(REQ), 32'd1);
      chk("rst_frame", 32'(FRAME), 32'd1);
      chk("rst_irdy", 32'(IRDY), 32'd1);
      chk("rst_oe", 32'(AD_oe), 32'd0);
      chk("rst_ad", AD_out, 32'd0);
      chk("rst_cbe", 32'(CBE), 32'hF);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_flags", {27'd0, busy, done, abort, rd_valid, wr_data_ack}, 32'd0);
      RST = 1'b0;
      @(negedge clk);

      // single-word write, delayed grant and delayed target
      run_single(4'b0111, 32'h1000_0040, 3'd1, 32'hDEADBEEF, 1, 1, 1'b0);

      // 4-word read with two wait states before the third word
      push(EV_RD, 32'h11); push(EV_RD, 32'h22); push(EV_RD, 32'h33); push(EV_RD, 32'h44);
      push(EV_DONE, 32'h0);
      begin_txn(4'b0110, 32'h2000_0000, 3'd4, 32'h0, 0, 1'b0);
      @(negedge clk);
      chk("rd_oe_p1", 32'(AD_oe), 32'd0);
      chk("rd_frame_p1", 32'(FRAME), 32'd0);
      DEVSEL = 1'b0; TRDY = 1'b0; AD_in = 32'h11;
      @(negedge clk);
      chk("rd_frame_p2", 32'(FRAME), 32'd0);
      AD_in = 32'h22;
      @(negedge clk);
      TRDY = 1'b1;
      chk("rd_frame_p3", 32'(FRAME), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rd_wait_frame", 32'(FRAME), 32'd0);
      chk("rd_wait_oe", 32'(AD_oe), 32'd0);
      TRDY = 1'b0; AD_in = 32'h33;
      @(negedge clk);
      chk("rd_frame_p4", 32'(FRAME), 32'd1);
      chk("rd_irdy_p4", 32'(IRDY), 32'd0);
      chk("rd_oe_p4", 32'(AD_oe), 32'd0);
      AD_in = 32'h44;
      @(negedge clk);
      TRDY = 1'b1; DEVSEL = 1'b1;
      chk("rd_turn_frame", 32'(FRAME), 32'd1);
      chk("rd_turn_irdy", 32'(IRDY), 32'd1);
      repeat (2) @(negedge clk);
      chk("rd_busy_end", 32'(busy), 32'd0);

      // master abort: DEVSEL never asserted
      push(EV_ABORT, 32'h0);
      begin_txn(4'b0111, 32'h3000_0000, 3'd2, 32'h5555_AAAA, 0, 1'b0);
      @(negedge clk);
      chk("ab_irdy_start", 32'(IRDY), 32'd0);
      repeat (4) @(negedge clk);
      chk("ab_not_early", 32'(IRDY), 32'd0);
      @(negedge clk);
      chk("ab_frame", 32'(FRAME), 32'd1);
      chk("ab_irdy", 32'(IRDY), 32'd1);
      chk("ab_oe", 32'(AD_oe), 32'd0);
      repeat (2) @(negedge clk);
      chk("ab_busy_end", 32'(busy), 32'd0);

      // num_words=0 behaves as a single phase
      run_single(4'b0111, 32'h4000_0010, 3'd0, 32'hCAFEF00D, 0, 0, 1'b0);

      // reset in the middle of a 3-word write burst
      begin_txn(4'b0111, 32'h5000_0000, 3'd3, 32'h0123_4567, 0, 1'b0);
      @(negedge clk);
      chk("rs_frame_mid", 32'(FRAME), 32'd0);
      DEVSEL = 1'b0;
      @(negedge clk);
      RST = 1'b1;
      #1;
      chk("rs_frame", 32'(FRAME), 32'd1);
      chk("rs_irdy", 32'(IRDY), 32'd1);
      chk("rs_req", 32'(REQ), 32'd1);
      chk("rs_oe", 32'(AD_oe), 32'd0);
      chk("rs_cbe", 32'(CBE), 32'hF);
      chk("rs_busy", 32'(busy), 32'd0);
      DEVSEL = 1'b1;
      @(negedge clk);
      RST = 1'b0;
      @(negedge clk);
      run_single(4'b0110, 32'h6000_0000, 3'd1, 32'h5A5A_1234, 0, 0, 1'b0);

      // start while busy and start in the cycle busy falls are both ignored
      run_single(4'b0111, 32'h7000_0000, 3'd1, 32'h7777_0001, 0, 0, 1'b1);
      run_single(4'b0110, 32'h8000_0000, 3'd1, 32'h8888_0002, 0, 0, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
